vector_lane_unit: RTL and testbench

- Parametrised, registered lane-manipulation unit for the vector processor datapath. It supersedes the fixed 128/32 four-lane scalar-to-lane move.
- Performs insert, extract, broadcast and multi-beat pack (scalar stream to vector) operations.
- Uses valid/ready handshakes on both sides so it can sit between the register-file read stage and the writeback stage.

---
 rtl/vector_lane_unit.sv | 141 ++++++++++++++
 tb/tb_vector_lane_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_lane_unit.sv
// vector_lane_unit: registered lane insert/extract/broadcast and multi-beat
// pack (scalar stream -> vector) with valid/ready on both sides.
// Optional feature macro: VLU_FLUSH_EN adds a flush input that emits a
// partially packed vector.
module vector_lane_unit #(
    parameter int V     = 128,
    parameter int N     = 32,
    parameter int LANES = V / N,
    parameter int IW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    op,
    input  logic [IW-1:0] idx,
    input  logic [N-1:0]  src,
    input  logic [V-1:0]  vec_in,
`ifdef VLU_FLUSH_EN
    input  logic          flush,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [V-1:0]  dst_vec,
    output logic [N-1:0]  dst_scalar,
    output logic          busy
);

    localparam logic [1:0] OP_INSERT    = 2'd0;
    localparam logic [1:0] OP_EXTRACT   = 2'd1;
    localparam logic [1:0] OP_BROADCAST = 2'd2;
    localparam logic [1:0] OP_PACK      = 2'd3;

    typedef enum logic {ST_IDLE, ST_PACK} state_t;

    state_t         state;
    logic [IW-1:0]  count;
    logic [V-1:0]   pbuf;

    logic           accept;
    logic           idx_ok;
    logic           pack_last;
    logic           flush_go;
    logic [V-1:0]   ins_vec;
    logic [N-1:0]   ext_val;
    logic [V-1:0]   pack_next;

    // Output slot is free when empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // Non-power-of-two lane counts leave idx codes that map to no lane.
    assign idx_ok   = (32'(idx) < 32'(LANES));

    // Final beat: the slot being written is the top lane.
    assign pack_last = (state == ST_IDLE) ? (LANES == 1) : (count == IW'(LANES - 1));

`ifdef VLU_FLUSH_EN
    assign flush_go = (state == ST_PACK) && flush && in_ready;
`else
    assign flush_go = 1'b0;
`endif

    // Lane select for insert/extract and the next pack buffer contents.
    always_comb begin
        ins_vec   = vec_in;
        ext_val   = '0;
        pack_next = (state == ST_IDLE) ? '0 : pbuf;
        for (int l = 0; l < LANES; l++) begin
            if (idx_ok && idx == IW'(l)) begin
                ins_vec[l*N +: N] = src;
                ext_val           = vec_in[l*N +: N];
            end
            if ((state == ST_IDLE && l == 0) || (state == ST_PACK && count == IW'(l)))
                pack_next[l*N +: N] = src;
        end
    end

    // Result register, pack sequencer and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            dst_vec    <= '0;
            dst_scalar <= '0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
            count      <= '0;
            pbuf       <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept) begin
                    case (op)
                        OP_INSERT: begin
                            out_valid  <= 1'b1;
                            dst_vec    <= ins_vec;
                            dst_scalar <= '0;
                        end
                        OP_EXTRACT: begin
                            out_valid  <= 1'b1;
                            dst_vec    <= vec_in;
                            dst_scalar <= ext_val;
                        end
                        OP_BROADCAST: begin
                            out_valid  <= 1'b1;
                            dst_vec    <= {LANES{src}};
                            dst_scalar <= src;
                        end
                        default: begin
                            if (pack_last) begin
                                out_valid  <= 1'b1;
                                dst_vec    <= pack_next;
                                dst_scalar <= '0;
                            end else begin
                                pbuf  <= pack_next;
                                count <= IW'(1);
                                state <= ST_PACK;
                                busy  <= 1'b1;
                            end
                        end
                    endcase
                end
            end else begin
                // Beats in PACK ignore op/idx/vec_in; flush emits what is filled so far.
                if ((accept && pack_last) || flush_go) begin
                    out_valid  <= 1'b1;
                    dst_vec    <= accept ? pack_next : pbuf;
                    dst_scalar <= '0;
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    count      <= '0;
                    pbuf       <= '0;
                end else if (accept) begin
                    pbuf  <= pack_next;
                    count <= count + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_lane_unit.sv
// Directed bench for vector_lane_unit: table-driven single-cycle ops plus
// hand sequences for back-pressure, pack, reset-abort and (optionally) flush,
// on a 128/32 instance and a 64/16 instance.
module tb_vector_lane_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 128/32 instance
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0]   op, idx;
    logic [31:0]  src, dst_scalar;
    logic [127:0] vec_in, dst_vec;
    logic         flush;

    // 64/16 instance
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [1:0]   b_op, b_idx;
    logic [15:0]  b_src, b_dst_scalar;
    logic [63:0]  b_vec_in, b_dst_vec;
    logic         b_flush;

    vector_lane_unit #(.V(128), .N(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .idx(idx), .src(src), .vec_in(vec_in),
`ifdef VLU_FLUSH_EN
        .flush(flush),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .dst_vec(dst_vec),
        .dst_scalar(dst_scalar), .busy(busy)
    );

    vector_lane_unit #(.V(64), .N(16)) dut64 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .op(b_op), .idx(b_idx), .src(b_src), .vec_in(b_vec_in),
`ifdef VLU_FLUSH_EN
        .flush(b_flush),
`endif
        .out_valid(b_out_valid), .out_ready(b_out_ready), .dst_vec(b_dst_vec),
        .dst_scalar(b_dst_scalar), .busy(b_busy)
    );

    typedef struct {
        logic [1:0]   op;
        logic [1:0]   idx;
        logic [31:0]  src;
        logic [127:0] vec;
        logic [127:0] ev;
        logic [31:0]  es;
    } vec_t;

    localparam logic [127:0] V0 = 128'h44444444_33333333_22222222_11111111;

    vec_t tbl[6];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] o, input logic [31:0] s);
        in_valid = 1'b1; op = o; src = s;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{2'd0, 2'd2, 32'hDEADBEEF, V0, 128'h44444444_DEADBEEF_22222222_11111111, 32'h0};
        tbl[1] = '{2'd0, 2'd0, 32'hCAFEF00D, V0, 128'h44444444_33333333_22222222_CAFEF00D, 32'h0};
        tbl[2] = '{2'd0, 2'd3, 32'h00000000, V0, 128'h00000000_33333333_22222222_11111111, 32'h0};
        tbl[3] = '{2'd1, 2'd3, 32'h0,        V0, V0, 32'h44444444};
        tbl[4] = '{2'd1, 2'd0, 32'h0,        V0, V0, 32'h11111111};
        tbl[5] = '{2'd2, 2'd1, 32'h000000A5, V0, {4{32'h000000A5}}, 32'h000000A5};

        rst = 1'b1; in_valid = 0; out_ready = 1; op = 0; idx = 0; src = 0; vec_in = 0; flush = 0;
        b_in_valid = 0; b_out_ready = 1; b_op = 0; b_idx = 0; b_src = 0; b_vec_in = 0; b_flush = 0;
        step(); step();
        rst = 1'b0;
        step();

        // reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dst_vec", dst_vec, 0);
        chk("rst_dst_scalar", dst_scalar, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);

        // table of single-cycle ops, issued back to back
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; op = tbl[i].op; idx = tbl[i].idx; src = tbl[i].src; vec_in = tbl[i].vec;
            step();
            chk($sformatf("tbl%0d_valid", i), out_valid, 1);
            chk($sformatf("tbl%0d_vec", i), dst_vec, tbl[i].ev);
            chk($sformatf("tbl%0d_scalar", i), dst_scalar, tbl[i].es);
        end
        in_valid = 0;
        step();
        chk("drain_valid", out_valid, 0);

        // back-pressure: EXTRACT held 5 cycles, competing BROADCAST not taken
        out_ready = 0;
        in_valid = 1; op = 2'd1; idx = 2'd3; vec_in = V0;
        step();
        op = 2'd2; src = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_scalar", dst_scalar, 32'h44444444);
            chk("bp_vec", dst_vec, V0);
            step();
        end
        in_valid = 0; out_ready = 1;
        step();
        chk("bp_release", out_valid, 0);

        // back-to-back BROADCAST then INSERT at full throughput
        in_valid = 1; op = 2'd2; src = 32'h000000A5;
        step();
        chk("b2b_0_valid", out_valid, 1);
        chk("b2b_0_vec", dst_vec, {4{32'h000000A5}});
        op = 2'd0; idx = 2'd2; src = 32'hDEADBEEF; vec_in = V0;
        step();
        chk("b2b_1_valid", out_valid, 1);
        chk("b2b_1_vec", dst_vec, 128'h44444444_DEADBEEF_22222222_11111111);
        in_valid = 0;
        step();

        // PACK 1..4 with gaps; later beats carry non-PACK op codes (ignored)
        beat(2'd3, 32'd1);
        chk("pk_busy1", busy, 1);
        chk("pk_novalid1", out_valid, 0);
        step(); step();
        beat(2'd0, 32'd2);
        step();
        beat(2'd1, 32'd3);
        chk("pk_busy3", busy, 1);
        chk("pk_novalid3", out_valid, 0);
        step(); step(); step();
        beat(2'd3, 32'd4);
        chk("pk_valid", out_valid, 1);
        chk("pk_vec", dst_vec, 128'h00000004_00000003_00000002_00000001);
        chk("pk_scalar", dst_scalar, 0);
        chk("pk_busy_end", busy, 0);
        step();

        // reset mid-PACK, then a clean 5..8 pack
        beat(2'd3, 32'd1);
        beat(2'd3, 32'd2);
        rst = 1;
        #2;
        chk("rstpk_busy", busy, 0);
        chk("rstpk_valid", out_valid, 0);
        rst = 0;
        step();
        for (int i = 5; i <= 8; i++) begin
            chk("rp_novalid", out_valid, 0);
            beat(2'd3, 32'(i));
        end
        chk("rp_valid", out_valid, 1);
        chk("rp_vec", dst_vec, 128'h00000008_00000007_00000006_00000005);
        step();

`ifdef VLU_FLUSH_EN
        // flush alone after two beats
        beat(2'd3, 32'd9);
        beat(2'd3, 32'd10);
        flush = 1;
        step();
        flush = 0;
        chk("fl_valid", out_valid, 1);
        chk("fl_vec", dst_vec, 128'h00000000_00000000_0000000A_00000009);
        chk("fl_busy", busy, 0);
        step();
        // flush together with a beat: beat written first
        beat(2'd3, 32'd1);
        flush = 1;
        beat(2'd3, 32'd2);
        flush = 0;
        chk("flb_vec", dst_vec, 128'h00000000_00000000_00000002_00000001);
        step();
        // flush in IDLE does nothing
        flush = 1;
        step();
        flush = 0;
        chk("fl_idle", out_valid, 0);
`endif

        // 64/16 instance
        b_in_valid = 1; b_op = 2'd0; b_idx = 2'd1; b_src = 16'hBEEF; b_vec_in = 64'h4444_3333_2222_1111;
        step();
        chk("b_ins_vec", b_dst_vec, 64'h4444_3333_BEEF_1111);
        b_op = 2'd1; b_idx = 2'd2;
        step();
        chk("b_ext_scalar", b_dst_scalar, 16'h3333);
        b_in_valid = 0;
        step();
        for (int i = 1; i <= 4; i++) begin
            b_in_valid = 1; b_op = 2'd3; b_src = 16'(i);
            step();
            if (i == 1) chk("b_pk_busy", b_busy, 1);
        end
        b_in_valid = 0;
        chk("b_pk_vec", b_dst_vec, 64'h0004_0003_0002_0001);
        chk("b_pk_valid", b_out_valid, 1);
`ifdef VLU_FLUSH_EN
        step();
        b_in_valid = 1; b_op = 2'd3; b_src = 16'h0009;
        step();
        b_in_valid = 0; b_flush = 1;
        step();
        b_flush = 0;
        chk("b_fl_vec", b_dst_vec, 64'h0000_0000_0000_0009);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
